rr_mux: RTL and testbench
=========================

# rr_mux

N-to-1 round-robin multiplexer with a valid/ready handshake on every channel. It is the gathering counterpart of the 1-to-N `demux`: it collects per-channel data beats from N requesters onto one registered output stream. The granted channel index is presented on `out_sel`, so a downstream `demux` can route responses back with `sel = out_sel`.

## Interface
Parameters:
- `N`, default 8: number of input channels; legal values are N ≥ 2, and N need not be a power of two.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: width of the select/index fields. It is derived from `N` and must never be overridden.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  N  per-channel request; bit i belongs to channel i.
- `in_data`  in  N*W  flattened channel data; channel i occupies bits `[i*W +: W]`.
- `in_ready`  out  N  per-channel accept. At most one bit is high in any cycle.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  data of the held beat.
- `out_sel`  out  SW  channel index of the held beat.
- `out_ready`  in  1  downstream accept.

## Operation
- A single output register holds `out_valid`, `out_data` and `out_sel`. A round-robin pointer `ptr` (SW bits) holds the highest-priority channel.
- Load condition: `load_ok = !out_valid || out_ready`.
- Grant rule:
  - Take the first channel g with `in_valid[g]=1`, scanning g = ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - If no channel is valid, there is no grant.
- Ready rule: `in_ready[g] = load_ok && grant_valid && (i==g)`. All other bits are 0.
  - `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`.
  - `in_ready` must not depend on `in_data`.
- A transfer occurs on channel g when `in_valid[g] && in_ready[g]`. At the next clock edge:
  - `out_data` ← channel g's data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `ptr` ← g+1, wrapping to 0 when g = N-1. This holds for any N, including non-powers of two.
- Drain: if `out_valid && out_ready` and there is no new transfer, then `out_valid` ← 0. `out_data` and `out_sel` hold their values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one and `out_valid` stays 1. This gives full throughput of one beat per cycle.
- When no transfer occurs, `ptr` is unchanged. Requests that arrive while the output is stalled do not rotate priority.
- The output is a sticky handshake. While `out_valid && !out_ready`, the values of `out_data` and `out_sel` are stable.
- Inputs are not required to be sticky. A channel may drop `in_valid` without being granted, and the block must tolerate this.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. While `rst=1`, `in_ready` is all-zero.
- Reset asserted mid-operation discards any held beat at that edge. No beat is emitted during reset or in the first cycle after it.
- Latency: 1 cycle from an input transfer to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` is held at 1.
- Fairness: with all N channels continuously valid and `out_ready=1`, each channel is granted exactly once in every N consecutive transfers.
- Backpressure: with `out_ready=0` and `out_valid=1`, no `in_ready` is asserted and no state changes.
- `out_*` are register outputs only; there is no combinational path from any input to them.

## Structure
- Shared package `mux_pkg`:
  - function `rr_pick(req, ptr)`, returning the grant index and a found flag;
  - function `idx_wrap(idx, n)`, the increment-with-wrap.
  - These functions are shared with any future arbiter.
- One sub-module, `rr_arbiter #(N)`: purely combinational. Inputs are `req[N]` and `ptr`; outputs are `gnt_idx[SW]` and `gnt_valid`.
- The top level holds the output register, the pointer, and the ready fan-out.
- Expected size: 150–250 lines of RTL total.

## Test plan
All scenarios use N=8, W=8.
- **Reset:** hold `rst=1` for 2 cycles with all channels valid → `out_valid=0`, `in_ready=0`, `out_sel=0`. After release, the first grant is channel 0.
- **Single channel sweep:**
  - Stimulus: for i = 0..7, drive only `in_valid[i]=1` with data 8'hA0+i, with `out_ready=1`.
  - Response: each beat appears one cycle later with `out_sel=i` and `out_data=8'hA0+i`.
- **All valid, `out_ready=1` for 16 cycles** → `out_sel` sequence is 0,1,…,7,0,…,7 with no gaps. Each channel's `in_ready` pulses once per 8 cycles.
- **Backpressure:**
  - Stimulus: channels 3 and 5 valid; `out_ready=0` for 4 cycles, then `out_ready=1`.
  - Response: 3 is granted first, and `out_data`/`out_sel` are stable during the stall. No `in_ready` is asserted during the stall. Channel 5 is granted next, with back-to-back beats once `out_ready=1`.
- **Wrap:** channels 7 and 0 valid, with `ptr=7` after a prior grant of channel 6 → order is 7 then 0, and `ptr` returns to 1.
- **Reset mid-stream:** assert `rst` while `out_valid=1` and `out_ready=0` → `out_valid=0` at the next edge, and the held beat is never observed accepted.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared arbitration helpers: round-robin pick and increment-with-wrap.
package mux_pkg;

  localparam int unsigned MAX_N  = 64;
  localparam int unsigned MAX_SW = 6;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1 (ptr < n).
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                    input logic [MAX_SW-1:0] ptr,
                                    input int unsigned       n);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned off = 0; off < MAX_N; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= n) cand = cand - n;
      if ((off < n) && !res.found && req[cand[MAX_SW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_SW-1:0];
      end
    end
    return res;
  endfunction

  // idx + 1, returning to 0 after n-1; valid for any n, power of two or not.
  function automatic logic [MAX_SW-1:0] idx_wrap(input logic [MAX_SW-1:0] idx,
                                                 input int unsigned       n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + MAX_SW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_valid
);

  pick_t pick;

  // Widen to the package's fixed-size helper and narrow the result back.
  always_comb begin
    pick      = rr_pick(MAX_N'(req), MAX_SW'(ptr), N);
    gnt_idx   = SW'(pick.idx);
    gnt_valid = pick.found;
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 round-robin mux with valid/ready per channel and a registered output stream.
module rr_mux
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [SW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          load_ok;
  logic          xfer;
  logic [W-1:0]  gnt_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Accept decision and one-hot ready fan-out; independent of in_data.
  always_comb begin
    load_ok  = !out_valid_q || out_ready;
    xfer     = load_ok && gnt_valid && !rst;
    in_ready = '0;
    if (xfer) in_ready = N'(1) << gnt_idx;
  end

  // Data of the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  // Next state: load on transfer (replaces a draining beat), otherwise drain or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      ptr_d       = SW'(idx_wrap(MAX_SW'(gnt_idx), N));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: directed stimulus pushes expected beats, a monitor pops on acceptance.
module tb_rr_mux;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  rr_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input int ch);
    logic [7:0] d;
    d = 8'hA0 + 8'(ch);
    return {3'(ch), d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, check in_ready, queue the expected beat (ch < 0: none).
  task automatic drive(input logic [7:0] v, input logic r, input logic [7:0] exp_rdy,
                       input int push_ch);
    in_valid  = v;
    out_ready = r;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (push_ch >= 0) exp_q.push_back(mk(push_ch));
    step();
  endtask

  // Monitor: every accepted output beat must match the head of the queue.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel=%0d data=%0h expected none", out_sel, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({out_sel, out_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    rst       = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready2", 32'(in_ready), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    rst = 1'b0;
    drive(8'hFF, 1'b1, 8'h01, 0);

    // Single channel sweep.
    for (int i = 0; i < 8; i++) drive(8'(1 << i), 1'b1, 8'(1 << i), i);
    drive(8'h00, 1'b1, 8'h00, -1);

    // All valid: strict rotation 0..7 twice, no gaps.
    for (int k = 0; k < 16; k++) drive(8'hFF, 1'b1, 8'(1 << (k % 8)), k % 8);
    drive(8'h00, 1'b1, 8'h00, -1);

    // Backpressure: 3 loads, stall 3 more cycles, then 5 and 3 back-to-back.
    drive(8'h28, 1'b0, 8'h08, 3);
    for (int s = 0; s < 3; s++) begin
      in_valid  = 8'h28;
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_sel", 32'(out_sel), 32'h3);
      chk("stall_data", 32'(out_data), 32'hA3);
      step();
    end
    drive(8'h28, 1'b1, 8'h20, 5);
    drive(8'h28, 1'b1, 8'h08, 3);
    drive(8'h00, 1'b1, 8'h00, -1);

    // Wrap: grant 6 sets ptr=7; 7 then 0; ptr back to 1.
    drive(8'h40, 1'b1, 8'h40, 6);
    drive(8'h81, 1'b1, 8'h80, 7);
    drive(8'h81, 1'b1, 8'h01, 0);
    drive(8'hFF, 1'b1, 8'h02, 1);
    drive(8'h00, 1'b1, 8'h00, -1);

    // Reset mid-stream discards a stalled beat and resets ptr.
    drive(8'h10, 1'b0, 8'h10, -1);
    chk("mid_held_valid", 32'(out_valid), 32'h1);
    in_valid  = 8'h00;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    step();
    chk("mid_rst_valid2", 32'(out_valid), 32'h0);
    rst = 1'b0;
    drive(8'h12, 1'b1, 8'h02, 1);
    drive(8'h00, 1'b1, 8'h00, -1);
    drive(8'h00, 1'b1, 8'h00, -1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
